// File: rtl/stdp_pair_requester.sv
// STDP pairing engine: tracks pre/post spike ages, requests plus/minus LUT
// deltas on each spike and applies them to a saturating signed weight.
module stdp_pair_requester #(
  parameter int                  W       = 24,
  parameter int                  AGE_MAX = 255,
  parameter logic signed [W-1:0] W_INIT  = 24'sh000000,
  parameter logic signed [W-1:0] W_MAX   = 24'sh3FFFFF,
  parameter logic signed [W-1:0] W_MIN   = -24'sh400000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         step_en,
  input  logic         pre_spike,
  input  logic         post_spike,
  input  logic         w_load,
  input  logic [W-1:0] w_init,
  output logic [7:0]   lutp_in,
  input  logic [W-1:0] lutp_out,
  output logic [7:0]   lutm_in,
  input  logic [W-1:0] lutm_out,
  output logic [W-1:0] weight,
  output logic         upd_valid,
  output logic         busy,
  output logic         overrun
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    APPLY = 2'd2
  } state_t;

  localparam logic [7:0] AGE_MAX_C = 8'(AGE_MAX);

  // Saturating age increment; also yields the dt for a pairing from a prior age.
  function automatic logic [7:0] age_inc(input logic [7:0] age);
    logic [7:0] r;
    if (age >= AGE_MAX_C) begin
      r = AGE_MAX_C;
    end else begin
      r = age + 8'd1;
    end
    return r;
  endfunction

  // Clamp the widened sum back into the legal weight range.
  function automatic logic signed [W-1:0] clamp_w(input logic signed [W+1:0] s);
    logic signed [W+1:0] hi;
    logic signed [W+1:0] lo;
    logic signed [W-1:0] r;
    hi = {{2{W_MAX[W-1]}}, W_MAX};
    lo = {{2{W_MIN[W-1]}}, W_MIN};
    if (s > hi) begin
      r = W_MAX;
    end else if (s < lo) begin
      r = W_MIN;
    end else begin
      r = s[W-1:0];
    end
    return r;
  endfunction

  state_t              state_r, state_s;
  logic [7:0]          pre_age_r, pre_age_s;
  logic [7:0]          post_age_r, post_age_s;
  logic [7:0]          lutp_in_r, lutp_in_s;
  logic [7:0]          lutm_in_r, lutm_in_s;
  logic signed [W-1:0] weight_r, weight_s;
  logic                upd_valid_r, upd_valid_s;
  logic                busy_r, busy_s;
  logic                overrun_r, overrun_s;
  logic                any_spike_s;
  logic signed [W+1:0] sum_s;

  assign any_spike_s = pre_spike | post_spike;

  // Two guard bits so weight plus two full-scale deltas cannot overflow.
  always_comb begin
    sum_s = {{2{weight_r[W-1]}}, weight_r}
          + {{2{lutp_out[W-1]}}, lutp_out}
          + {{2{lutm_out[W-1]}}, lutm_out};
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic: a spiking step starts the lookup/apply sequence.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (step_en && any_spike_s) begin
          state_s = WAIT;
        end else begin
          state_s = IDLE;
        end
      end
      WAIT:    state_s = APPLY;
      APPLY:   state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Next values of the registered outputs, ages and weight.
  always_comb begin
    pre_age_s   = pre_age_r;
    post_age_s  = post_age_r;
    lutp_in_s   = lutp_in_r;
    lutm_in_s   = lutm_in_r;
    weight_s    = weight_r;
    upd_valid_s = 1'b0;
    busy_s      = busy_r;
    overrun_s   = overrun_r;
    case (state_r)
      IDLE: begin
        if (step_en) begin
          // dt uses the ages from before this step's update.
          if (post_spike) begin
            lutp_in_s = age_inc(pre_age_r);
          end else begin
            lutp_in_s = 8'd0;
          end
          if (pre_spike) begin
            lutm_in_s = age_inc(post_age_r);
          end else begin
            lutm_in_s = 8'd0;
          end
          pre_age_s  = pre_spike  ? 8'd0 : age_inc(pre_age_r);
          post_age_s = post_spike ? 8'd0 : age_inc(post_age_r);
          busy_s     = any_spike_s;
        end else if (w_load) begin
          weight_s = w_init;
        end else begin
          busy_s = 1'b0;
        end
      end
      WAIT: begin
        busy_s = 1'b1;
        if (step_en) begin
          overrun_s = 1'b1;
        end else begin
          overrun_s = overrun_r;
        end
      end
      APPLY: begin
        weight_s    = clamp_w(sum_s);
        upd_valid_s = 1'b1;
        lutp_in_s   = 8'd0;
        lutm_in_s   = 8'd0;
        busy_s      = 1'b0;
        if (step_en) begin
          overrun_s = 1'b1;
        end else begin
          overrun_s = overrun_r;
        end
      end
      default: begin
        lutp_in_s = 8'd0;
        lutm_in_s = 8'd0;
        busy_s    = 1'b0;
      end
    endcase
  end

  // Datapath and output registers; reset also aborts any pairing in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_age_r   <= AGE_MAX_C;
      post_age_r  <= AGE_MAX_C;
      lutp_in_r   <= 8'd0;
      lutm_in_r   <= 8'd0;
      weight_r    <= W_INIT;
      upd_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      overrun_r   <= 1'b0;
    end else begin
      pre_age_r   <= pre_age_s;
      post_age_r  <= post_age_s;
      lutp_in_r   <= lutp_in_s;
      lutm_in_r   <= lutm_in_s;
      weight_r    <= weight_s;
      upd_valid_r <= upd_valid_s;
      busy_r      <= busy_s;
      overrun_r   <= overrun_s;
    end
  end

  assign lutp_in   = lutp_in_r;
  assign lutm_in   = lutm_in_r;
  assign weight    = weight_r;
  assign upd_valid = upd_valid_r;
  assign busy      = busy_r;
  assign overrun   = overrun_r;

endmodule

// File: tb/tb_stdp_pair_requester.sv
// Scoreboard bench for stdp_pair_requester with registered plus/minus LUT models.
module tb_stdp_pair_requester;

  typedef struct {
    int lp;
    int lm;
    int w;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        step_en = 1'b0;
  logic        pre_spike = 1'b0;
  logic        post_spike = 1'b0;
  logic        w_load = 1'b0;
  logic [23:0] w_init = 24'h000000;
  logic [7:0]  lutp_in, lutm_in;
  logic [23:0] lutp_out = 24'h000000;
  logic [23:0] lutm_out = 24'h000000;
  logic [23:0] weight;
  logic        upd_valid, busy, overrun;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   lut_mode = 0;
  int   pre_age_m, post_age_m, weight_m;
  exp_t sb[$];

  stdp_pair_requester dut (
    .clk(clk), .rst(rst), .step_en(step_en), .pre_spike(pre_spike),
    .post_spike(post_spike), .w_load(w_load), .w_init(w_init),
    .lutp_in(lutp_in), .lutp_out(lutp_out), .lutm_in(lutm_in),
    .lutm_out(lutm_out), .weight(weight), .upd_valid(upd_valid),
    .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  function automatic int plus_f(input int mode, input int dt);
    if (dt == 0) return 0;
    if (mode == 1) return 32;
    if (mode == 2) return -32;
    if (dt >= 100) return 0;
    return -(dt * 4 + 8);
  endfunction

  function automatic int minus_f(input int mode, input int dt);
    if (dt == 0) return 0;
    if (mode == 1) return 32;
    if (mode == 2) return -32;
    if (dt >= 100) return 0;
    return dt * 3;
  endfunction

  function automatic int sat_m(input int a);
    return (a >= 255) ? 255 : a + 1;
  endfunction

  function automatic int clamp_m(input int s);
    if (s > 4194303) return 4194303;
    if (s < -4194304) return -4194304;
    return s;
  endfunction

  // Registered LUT models, one cycle of latency.
  always @(posedge clk) begin
    lutp_out <= 24'(plus_f(lut_mode, int'(lutp_in)));
    lutm_out <= 24'(minus_f(lut_mode, int'(lutm_in)));
  end

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    pre_age_m = 255;
    post_age_m = 255;
    weight_m = 0;
    sb.delete();
  endtask

  task automatic do_wload(input logic [23:0] v);
    w_load = 1'b1;
    w_init = v;
    @(posedge clk); #1;
    w_load = 1'b0;
    weight_m = int'($signed(v));
    n_cmp++;
    if (weight !== v) begin
      n_bad++;
      $display("FAIL wload: weight=%h expected %h", weight, v);
    end
  endtask

  // One accepted step; spiking steps push their expectation and are checked
  // through the lookup and the weight update.
  task automatic do_step(input logic pre, input logic post);
    int   dtp, dtm, k;
    exp_t e;
    dtp = post ? sat_m(pre_age_m) : 0;
    dtm = pre ? sat_m(post_age_m) : 0;
    pre_age_m  = pre ? 0 : sat_m(pre_age_m);
    post_age_m = post ? 0 : sat_m(post_age_m);
    if (pre || post) begin
      weight_m = clamp_m(weight_m + plus_f(lut_mode, dtp) + minus_f(lut_mode, dtm));
      e = '{dtp, dtm, weight_m};
      sb.push_back(e);
    end
    step_en = 1'b1;
    pre_spike = pre;
    post_spike = post;
    @(posedge clk); #1;
    step_en = 1'b0;
    pre_spike = 1'b0;
    post_spike = 1'b0;
    if (pre || post) begin
      e = sb[0];
      n_cmp++;
      if (busy !== 1'b1 || lutp_in !== 8'(e.lp) || lutm_in !== 8'(e.lm)) begin
        n_bad++;
        $display("FAIL lookup: busy=%b lutp_in=%0d lutm_in=%0d expected busy=1 lutp_in=%0d lutm_in=%0d",
                 busy, lutp_in, lutm_in, e.lp, e.lm);
      end
      k = 0;
      while (k < 6) begin
        @(posedge clk); #1;
        k++;
        if (upd_valid === 1'b1) break;
      end
      n_cmp++;
      if (k !== 2) begin
        n_bad++;
        $display("FAIL upd_latency: upd_valid after %0d cycles expected 2", k);
      end
      e = sb.pop_front();
      n_cmp++;
      if (weight !== 24'(e.w) || busy !== 1'b0) begin
        n_bad++;
        $display("FAIL weight_update: weight=%h busy=%b expected weight=%h busy=0",
                 weight, busy, 24'(e.w));
      end
    end else begin
      repeat (2) begin
        @(posedge clk); #1;
        n_cmp++;
        if (busy !== 1'b0 || upd_valid !== 1'b0 || lutp_in !== 8'd0 || lutm_in !== 8'd0) begin
          n_bad++;
          $display("FAIL idle_step: busy=%b upd_valid=%b lutp_in=%0d lutm_in=%0d expected all 0",
                   busy, upd_valid, lutp_in, lutm_in);
        end
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if (weight !== 24'h000000 || lutp_in !== 8'd0 || lutm_in !== 8'd0 ||
        upd_valid !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0) begin
      n_bad++;
      $display("FAIL reset: weight=%h lutp=%0d lutm=%0d upd=%b busy=%b ovr=%b expected all 0",
               weight, lutp_in, lutm_in, upd_valid, busy, overrun);
    end
  endtask

  task automatic test_post_first();
    do_reset();
    lut_mode = 0;
    do_step(1'b0, 1'b1);
    // Post age is now 0: a pre spike pairs with dt=1.
    do_step(1'b1, 1'b0);
  endtask

  task automatic test_pre_then_post();
    do_reset();
    lut_mode = 0;
    do_step(1'b1, 1'b0);
    repeat (4) do_step(1'b0, 1'b0);
    do_step(1'b0, 1'b1);
    n_cmp++;
    if (weight !== 24'hFFFFE4) begin
      n_bad++;
      $display("FAIL pre_post_dt5: weight=%h expected FFFFE4", weight);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    lut_mode = 0;
    do_step(1'b0, 1'b1);
    do_step(1'b1, 1'b0);
    do_step(1'b0, 1'b0);
    do_step(1'b1, 1'b1);
    do_step(1'b0, 1'b0);
    do_step(1'b1, 1'b1);
  endtask

  task automatic test_clamp();
    do_reset();
    do_wload(24'h3FFFF0);
    lut_mode = 1;
    do_step(1'b1, 1'b1);
    n_cmp++;
    if (weight !== 24'h3FFFFF) begin
      n_bad++;
      $display("FAIL clamp_max: weight=%h expected 3FFFFF", weight);
    end
    do_wload(24'hC00010);
    lut_mode = 2;
    do_step(1'b1, 1'b1);
    n_cmp++;
    if (weight !== 24'hC00000) begin
      n_bad++;
      $display("FAIL clamp_min: weight=%h expected C00000", weight);
    end
    lut_mode = 0;
  endtask

  task automatic test_step_beats_wload();
    do_reset();
    do_wload(24'h000040);
    pre_age_m = sat_m(pre_age_m);
    post_age_m = sat_m(post_age_m);
    step_en = 1'b1;
    w_load = 1'b1;
    w_init = 24'h000555;
    @(posedge clk); #1;
    step_en = 1'b0;
    w_load = 1'b0;
    n_cmp++;
    if (weight !== 24'h000040) begin
      n_bad++;
      $display("FAIL step_wins: weight=%h expected 000040", weight);
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_overrun();
    do_reset();
    lut_mode = 0;
    pre_age_m = 0;
    post_age_m = 255;
    step_en = 1'b1;
    pre_spike = 1'b1;
    @(posedge clk); #1;
    pre_spike = 1'b0;
    post_spike = 1'b1;
    w_load = 1'b1;
    w_init = 24'h000123;
    @(posedge clk); #1;
    step_en = 1'b0;
    post_spike = 1'b0;
    w_load = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (overrun !== 1'b1 || upd_valid !== 1'b1 || weight !== 24'h000000) begin
      n_bad++;
      $display("FAIL overrun: overrun=%b upd=%b weight=%h expected 1 1 000000",
               overrun, upd_valid, weight);
    end
    // Dropped post step left pre_age at 0, so this pairing must use dt=1.
    do_step(1'b0, 1'b1);
    n_cmp++;
    if (overrun !== 1'b1) begin
      n_bad++;
      $display("FAIL overrun_sticky: overrun=%b expected 1", overrun);
    end
  endtask

  task automatic test_reset_mid();
    logic seen;
    do_reset();
    do_wload(24'h000100);
    lut_mode = 1;
    step_en = 1'b1;
    post_spike = 1'b1;
    @(posedge clk); #1;
    step_en = 1'b0;
    post_spike = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_cmp++;
    if (weight !== 24'h000000 || busy !== 1'b0 || lutp_in !== 8'd0) begin
      n_bad++;
      $display("FAIL reset_mid: weight=%h busy=%b lutp=%0d expected 000000 0 0",
               weight, busy, lutp_in);
    end
    seen = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (upd_valid !== 1'b0 || weight !== 24'h000000) seen = 1'b1;
    end
    n_cmp++;
    if (seen !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_abort: update seen=%b expected 0", seen);
    end
    lut_mode = 0;
    pre_age_m = 255;
    post_age_m = 255;
    weight_m = 0;
    sb.delete();
    do_step(1'b1, 1'b0);
  endtask

  task automatic test_back_to_back();
    do_reset();
    lut_mode = 0;
    for (int i = 0; i < 24; i++) begin
      do_step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    n_cmp++;
    if (overrun !== 1'b0) begin
      n_bad++;
      $display("FAIL back_to_back_overrun: overrun=%b expected 0", overrun);
    end
  endtask

  initial begin
    test_reset();
    test_post_first();
    test_pre_then_post();
    test_simultaneous();
    test_clamp();
    test_step_beats_wload();
    test_overrun();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/stdp_pair_requester.md
Name: stdp_pair_requester

Overview:
- Per-synapse STDP pairing engine that drives the lookup tables (it is their requester).
- Tracks elapsed timesteps since the last pre- and post-synaptic spike.
- On each spike it issues the spike-time difference to a plus LUT (post-triggered pairing) and a minus LUT (pre-triggered pairing).
- Waits the LUTs' one-cycle registered latency, then applies the signed deltas to a saturating weight register consumed by the layer block.

Parameters:
W, 24, weight and LUT output width (signed two's complement)
AGE_MAX, 255, saturation value of age counters; also the "no spike yet" value
W_INIT, 0, weight value after reset
W_MAX, 24'sh3FFFFF, upper clamp on weight
W_MIN, -24'sh400000, lower clamp on weight

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
step_en  in  1  one-cycle pulse marking an algorithm timestep
pre_spike  in  1  pre-synaptic spike; sampled only when step_en=1
post_spike  in  1  post-synaptic spike; sampled only when step_en=1
w_load  in  1  load w_init into the weight (only accepted in IDLE)
w_init  in  W  value to load
lutp_in  out  8  dt to plus LUT
lutp_out  in  W  signed delta from plus LUT (registered, 1-cycle latency)
lutm_in  out  8  dt to minus LUT
lutm_out  in  W  signed delta from minus LUT (registered, 1-cycle latency)
weight  out  W  current weight
upd_valid  out  1  one-cycle pulse: weight just updated by a pairing
busy  out  1  pairing in progress
overrun  out  1  sticky: step_en arrived while busy

Behaviour:
- Reset (rst=1 at a clk edge):
  - All outputs, state and counters: weight=W_INIT; lutp_in=lutm_in=0; upd_valid=0; busy=0; overrun=0.
  - pre_age=post_age=AGE_MAX; state=IDLE.
  - Reset mid-pairing aborts it; no weight update occurs.
- Ages (8-bit, unsigned), updated on every accepted step_en:
  - Spike in that step -> age<=0.
  - Otherwise -> age<=min(age+1, AGE_MAX).
- dt for a pairing = min(prior_age+1, AGE_MAX), using the age before this step's update.
  - Example: pre spike at step k, post spike at step k+5 -> dt=5.
- States are IDLE, WAIT and APPLY. Cycle T = the cycle in which step_en=1 is accepted.
- IDLE, cycle T (step_en=1):
  - post_spike=1 -> lutp_in<=dt(pre_age).
  - pre_spike=1 -> lutm_in<=dt(post_age).
  - Unrequested LUT input <= 0 (the LUT returns 0 for 0).
  - Ages update as above.
  - Any spike present -> next state WAIT; otherwise stay IDLE and issue no lookup.
- WAIT (T+1): busy=1; lut inputs held; the LUTs register their result.
- APPLY (T+2):
  - busy=1.
  - sum = weight + sext(lutp_out) + sext(lutm_out), computed in W+2 bits.
  - weight<=clamp(sum, W_MIN, W_MAX); upd_valid<=1 (visible T+3).
  - lutp_in, lutm_in <= 0; next state IDLE.
- Update latency: spike step to new weight visible = 3 cycles; minimum step_en spacing = 3 cycles.
- Simultaneous pre and post in one step:
  - Both lookups issue in parallel, each using prior ages.
  - Both deltas are summed in the single APPLY; both ages reset to 0.
- step_en while busy (WAIT/APPLY):
  - Step dropped: no age update, no lookup; overrun<=1 (sticky until rst).
- Age saturation:
  - Ages never wrap. dt=AGE_MAX is still issued (LUT returns 0 outside its window).
- w_load:
  - Accepted in IDLE only when step_en=0: weight<=w_init next cycle.
  - If step_en and w_load coincide, step_en wins and w_load is ignored.
  - w_load while busy is ignored.
- upd_valid pulses after every APPLY, even if the net delta is 0.

Test Plan:
- Reset, then post_spike at step 0 with no prior pre -> lutp_in=255, lutm_in=0; weight stays 0; upd_valid pulse at T+3; ages pre=256-sat=255, post=0.
- pre_spike at step 0, post_spike at step 5 (plus LUT returning 24'hFFFFE4 for dt=5) -> lutp_in=5 visible T+1; weight 0 -> -28 (24'hFFFFE4) at T+3.
- pre and post both at step 3 after pre at step 1 and post at step 0 -> lutp_in=2, lutm_in=3; weight = 0 + lutp(2) + lutm(3) in one update; both ages become 0.
- w_load w_init=24'h3FFFF0, then plus/minus LUT models returning +32 -> weight clamps to W_MAX=24'h3FFFFF; a second case at W_MIN clamps to 24'hC00000.
- step_en at T and again at T+1 -> second step dropped, overrun=1 sticky, ages reflect only the first step.
- rst asserted at T+1 during WAIT -> weight=W_INIT, busy=0, no upd_valid, ages=255.
